// File: rtl/alu_issue_if.sv
// Bundles the fetch handshake, ALU issue/return, branch report and debug read
// signals between the issue controller and its environment.
interface alu_issue_if #(
    parameter int DATA_W = 16
);
    logic              instr_valid;
    logic              instr_ready;
    logic [15:0]       instr;
    logic [3:0]        alu_opcode;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic              alu_zero;
    logic [DATA_W-1:0] alu_result;
    logic              br_valid;
    logic              br_taken;
    logic [3:0]        br_offset;
    logic              illegal;
    logic [3:0]        dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        input  instr_valid, instr, alu_zero, alu_result, dbg_addr,
        output instr_ready, alu_opcode, alu_a, alu_b,
               br_valid, br_taken, br_offset, illegal, dbg_data
    );

    modport slave (
        output instr_valid, instr, alu_zero, alu_result, dbg_addr,
        input  instr_ready, alu_opcode, alu_a, alu_b,
               br_valid, br_taken, br_offset, illegal, dbg_data
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue controller for a registered ALU: decodes 16-bit instructions, reads a
// 16-entry register file, drives the ALU, writes results back and reports branches.
module alu_issue_ctrl #(
    parameter int         DATA_W = 16,
    parameter logic [3:0] NOP_OP = 4'b0000
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_issue_if.master  bus
);
    localparam logic [3:0] OP_LI  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_BEQ = 4'b0100;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_WB    = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_instr_ready;
    logic [3:0]        r_op;
    logic [3:0]        r_rd;
    logic [3:0]        r_off;
    logic [3:0]        r_alu_opcode;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [DATA_W-1:0] r_result;
    logic              r_br_valid;
    logic              r_br_taken;
    logic [3:0]        r_br_offset;
    logic              r_illegal;
    logic [DATA_W-1:0] r_regs [16];

    logic              w_fire;
    logic [3:0]        w_op;
    logic              w_is_li;
    logic              w_is_alu;
    logic              w_is_illegal;
    logic [3:0]        w_src_a;
    logic [3:0]        w_src_b;
    logic [DATA_W-1:0] w_val_a;
    logic [DATA_W-1:0] w_val_b;
    logic              w_wb_en;

    assign w_fire       = bus.instr_valid & r_instr_ready;
    assign w_op         = bus.instr[15:12];
    assign w_is_li      = (w_op == OP_LI);
    assign w_is_alu     = (w_op == OP_ADD) || (w_op == OP_SUB) || (w_op == OP_BEQ);
    assign w_is_illegal = !w_is_li && !w_is_alu;

    // BEQ has no destination, so its rd slot names the first compare register
    // and [3:0] is free to carry the branch offset.
    assign w_src_a = (w_op == OP_BEQ) ? bus.instr[11:8] : bus.instr[7:4];
    assign w_src_b = (w_op == OP_BEQ) ? bus.instr[7:4]  : bus.instr[3:0];
    assign w_val_a = (w_src_a == 4'd0) ? {DATA_W{1'b0}} : r_regs[w_src_a];
    assign w_val_b = (w_src_b == 4'd0) ? {DATA_W{1'b0}} : r_regs[w_src_b];

    assign w_wb_en = (r_state == S_WB) && ((r_op == OP_ADD) || (r_op == OP_SUB))
                     && (r_rd != 4'd0);

    // Next-state decode for the issue sequence
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_fire && w_is_alu) begin
                    w_state_nxt = S_ISSUE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  w_state_nxt = S_WB;
            S_WB:    w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register and registered ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_instr_ready <= 1'b1;
        end else begin
            r_state       <= w_state_nxt;
            r_instr_ready <= (w_state_nxt == S_IDLE);
        end
    end

    // Instruction latch, ALU drive and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op         <= 4'd0;
            r_rd         <= 4'd0;
            r_off        <= 4'd0;
            r_alu_opcode <= NOP_OP;
            r_alu_a      <= {DATA_W{1'b0}};
            r_alu_b      <= {DATA_W{1'b0}};
            r_result     <= {DATA_W{1'b0}};
        end else begin
            if (w_fire) begin
                r_op  <= w_op;
                r_rd  <= bus.instr[11:8];
                r_off <= bus.instr[3:0];
            end
            if (w_fire && w_is_alu) begin
                r_alu_opcode <= (w_op == OP_BEQ) ? OP_SUB : w_op;
                r_alu_a      <= w_val_a;
                r_alu_b      <= w_val_b;
            end else begin
                r_alu_opcode <= NOP_OP;
            end
            if (r_state == S_WAIT) begin
                r_result <= bus.alu_result;
            end
        end
    end

    // Branch report and illegal-opcode pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_br_valid  <= 1'b0;
            r_br_taken  <= 1'b0;
            r_br_offset <= 4'd0;
            r_illegal   <= 1'b0;
        end else begin
            if ((r_state == S_WAIT) && (r_op == OP_BEQ)) begin
                r_br_valid  <= 1'b1;
                r_br_taken  <= bus.alu_zero;
                r_br_offset <= r_off;
            end else begin
                r_br_valid  <= 1'b0;
                r_br_taken  <= 1'b0;
                r_br_offset <= 4'd0;
            end
            r_illegal <= w_fire && w_is_illegal;
        end
    end

    // Register file; r0 is never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (w_fire && w_is_li && (bus.instr[11:8] != 4'd0)) begin
                r_regs[bus.instr[11:8]] <= {{(DATA_W-8){1'b0}}, bus.instr[7:0]};
            end else if (w_wb_en) begin
                r_regs[r_rd] <= r_result;
            end
        end
    end

    assign bus.instr_ready = r_instr_ready;
    assign bus.alu_opcode  = r_alu_opcode;
    assign bus.alu_a       = r_alu_a;
    assign bus.alu_b       = r_alu_b;
    assign bus.br_valid    = r_br_valid;
    assign bus.br_taken    = r_br_taken;
    assign bus.br_offset   = r_br_offset;
    assign bus.illegal     = r_illegal;
    assign bus.dbg_data    = (bus.dbg_addr == 4'd0) ? {DATA_W{1'b0}} : r_regs[bus.dbg_addr];
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed cases plus random instruction
// streams compared against a transaction-level register-file model.
module tb_alu_issue_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_issue_if #(.DATA_W(16)) bus();

    alu_issue_ctrl #(.DATA_W(16), .NOP_OP(4'b0000)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] ref_regs [16];

    // Registered ALU: samples opcode/a/b at the edge, holds result on NOP
    logic [15:0] alu_res_r;
    logic        alu_zero_r;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_res_r  <= 16'h0000;
            alu_zero_r <= 1'b0;
        end else if (bus.alu_opcode == 4'b0010) begin
            alu_res_r  <= bus.alu_a + bus.alu_b;
            alu_zero_r <= 1'b0;
        end else if (bus.alu_opcode == 4'b0011) begin
            alu_res_r  <= bus.alu_a - bus.alu_b;
            alu_zero_r <= ((bus.alu_a - bus.alu_b) == 16'h0000);
        end
    end
    assign bus.alu_result = alu_res_r;
    assign bus.alu_zero   = alu_zero_r;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic peek(input logic [3:0] a, output logic [15:0] d);
        bus.dbg_addr = a;
        #1;
        d = bus.dbg_data;
    endtask

    task automatic sweep(input string tag);
        logic [15:0] d;
        for (int i = 0; i < 16; i++) begin
            peek(i[3:0], d);
            chk(tag, d, ref_regs[i]);
        end
    endtask

    // Presents one instruction, waits for acceptance, then follows it to completion.
    // Called (and returns) shortly after a rising edge.
    task automatic issue(input logic [15:0] ins);
        logic [3:0]  op, rd;
        logic [15:0] va, vb, d;
        bit          ok;
        op = ins[15:12];
        rd = ins[11:8];
        if (op == 4'h4) begin
            va = ref_regs[ins[11:8]];
            vb = ref_regs[ins[7:4]];
        end else begin
            va = ref_regs[ins[7:4]];
            vb = ref_regs[ins[3:0]];
        end
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 8; k++) begin
            ok = bus.instr_ready;
            @(posedge clk); #1;
            if (ok) break;
        end
        bus.instr_valid = 1'b0;
        if (!ok) begin
            chk("accept_timeout", 32'd0, 32'd1);
            return;
        end
        case (op)
            4'h1: begin
                if (rd != 4'd0) ref_regs[rd] = {8'h00, ins[7:0]};
                chk("li_ready", bus.instr_ready, 1'b1);
                peek(rd, d);
                chk("li_write", d, ref_regs[rd]);
            end
            4'h2, 4'h3, 4'h4: begin
                chk("iss_opcode", bus.alu_opcode, (op == 4'h2) ? 4'h2 : 4'h3);
                chk("iss_a", bus.alu_a, va);
                chk("iss_b", bus.alu_b, vb);
                chk("iss_ready", bus.instr_ready, 1'b0);
                @(posedge clk); #1;
                chk("wait_nop", bus.alu_opcode, 4'h0);
                chk("wait_brv", bus.br_valid, 1'b0);
                @(posedge clk); #1;
                chk("wb_brv", bus.br_valid, (op == 4'h4));
                if (op == 4'h4) begin
                    chk("wb_taken", bus.br_taken, (va == vb));
                    chk("wb_off", bus.br_offset, ins[3:0]);
                end
                @(posedge clk); #1;
                chk("done_brv", bus.br_valid, 1'b0);
                chk("done_ready", bus.instr_ready, 1'b1);
                if (op != 4'h4 && rd != 4'd0) ref_regs[rd] = (op == 4'h2) ? va + vb : va - vb;
                peek(rd, d);
                chk("wb_value", d, ref_regs[rd]);
            end
            default: begin
                chk("ill_pulse", bus.illegal, 1'b1);
                chk("ill_ready", bus.instr_ready, 1'b1);
                @(posedge clk); #1;
                chk("ill_clear", bus.illegal, 1'b0);
            end
        endcase
    endtask

    initial begin
        logic [15:0] d;
        logic [3:0]  op;
        int          accepts, last;
        bit          rdy;

        bus.instr_valid = 1'b0;
        bus.instr       = 16'h0000;
        bus.dbg_addr    = 4'd0;
        for (int i = 0; i < 16; i++) ref_regs[i] = 16'h0000;

        #12;
        chk("rst_ready", bus.instr_ready, 1'b1);
        chk("rst_opcode", bus.alu_opcode, 4'h0);
        chk("rst_brv", bus.br_valid, 1'b0);
        chk("rst_illegal", bus.illegal, 1'b0);
        sweep("rst_reg");
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        issue(16'h1105);
        issue(16'h1203);
        issue(16'h2312);
        issue(16'h1100);
        issue(16'h1201);
        issue(16'h3412);
        issue(16'h2542);
        issue(16'h411E);
        issue(16'h412A);
        issue(16'h2012);
        issue(16'hF123);
        sweep("dir_reg");

        // Back-to-back accumulating ADDs with valid held high
        issue(16'h1107);
        bus.instr       = 16'h2661;
        bus.instr_valid = 1'b1;
        accepts = 0;
        last    = 0;
        for (int c = 0; c < 24 && accepts < 3; c++) begin
            rdy = bus.instr_ready;
            @(posedge clk); #1;
            if (rdy) begin
                if (accepts > 0) chk("b2b_gap", c - last, 4);
                last = c;
                accepts++;
                ref_regs[6] = ref_regs[6] + ref_regs[1];
            end
        end
        bus.instr_valid = 1'b0;
        chk("b2b_count", accepts, 3);
        repeat (3) @(posedge clk);
        #1;
        peek(4'd6, d);
        chk("b2b_r6", d, ref_regs[6]);

        // Reset while the ALU result is pending
        bus.instr       = 16'h2712;
        bus.instr_valid = 1'b1;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) ref_regs[i] = 16'h0000;
        chk("mid_rst_ready", bus.instr_ready, 1'b1);
        chk("mid_rst_opcode", bus.alu_opcode, 4'h0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("mid_rst_brv", bus.br_valid, 1'b0);
            chk("mid_rst_idle", bus.instr_ready, 1'b1);
        end
        peek(4'd7, d);
        chk("mid_rst_r7", d, 16'h0000);

        // Random instruction stream
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: op = 4'h1;
                3, 4:    op = 4'h2;
                5, 6:    op = 4'h3;
                7, 8:    op = 4'h4;
                default: begin
                    op = 4'($urandom_range(4, 15));
                    if (op == 4'h4) op = 4'h0;
                end
            endcase
            issue({op, 12'($urandom_range(0, 4095))});
        end
        sweep("rand_reg");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
